// File: rtl/dp_pkg.sv
// Shared constants and FSM state encoding for the MNIST dot-product scheduler.
package dp_pkg;

    localparam int unsigned ROWS        = 28;
    localparam int unsigned PIXELS      = 784;
    localparam int unsigned NUM_NEURONS = 10;
    localparam int unsigned RESULT_W    = 26;
    localparam int unsigned WEIGHT_W    = 19;
    localparam int unsigned PIXEL_W     = 10;

    typedef logic [2:0] state_t;

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] CLEAR   = 3'd1;
    localparam logic [2:0] FEED    = 3'd2;
    localparam logic [2:0] WAIT    = 3'd3;
    localparam logic [2:0] CAPTURE = 3'd4;
    localparam logic [2:0] FINISH  = 3'd5;

endpackage

// File: rtl/dp_argmax_tracker.sv
// Running signed argmax over neuron results; the first capture of a run always wins,
// later captures win only on a strictly greater value so ties keep the lower index.
module dp_argmax_tracker #(
    parameter int unsigned RESULT_W = dp_pkg::RESULT_W,
    parameter int unsigned NEUR_AW  = 4
) (
    input  logic                       clk,
    input  logic                       GlobalReset,
    input  logic                       capture,
    input  logic                       first,
    input  logic [NEUR_AW-1:0]         index,
    input  logic signed [RESULT_W-1:0] value,
    output logic [NEUR_AW-1:0]         class_out,
    output logic signed [RESULT_W-1:0] max_value
);
    import dp_pkg::*;

    logic take;

    assign take = capture && (first || (value > max_value));

    always_ff @(posedge clk) begin
        if (GlobalReset) begin
            class_out <= '0;
            max_value <= '0;
        end else if (take) begin
            class_out <= index;
            max_value <= value;
        end
    end

endmodule

// File: rtl/dot_product_scheduler.sv
// Sequences the 28-lane dot-product engine over all output neurons and tracks the argmax.
// Optional WAIT watchdog enabled by defining DP_SCHED_TIMEOUT_EN (adds TIMEOUT_CYCLES).
module dot_product_scheduler #(
    parameter int unsigned ROWS           = dp_pkg::ROWS,
    parameter int unsigned NUM_NEURONS    = dp_pkg::NUM_NEURONS,
    parameter int unsigned RESULT_W       = dp_pkg::RESULT_W,
`ifdef DP_SCHED_TIMEOUT_EN
    parameter int unsigned TIMEOUT_CYCLES = 512,
`endif
    parameter int unsigned ROW_AW         = 5,
    parameter int unsigned NEUR_AW        = 4
) (
    input  logic                       clk,
    input  logic                       GlobalReset,
    input  logic                       start,
    input  logic                       feed_ready,
    input  logic                       result_valid,
    input  logic signed [RESULT_W-1:0] result_in,
    output logic                       busy,
    output logic                       engine_clear,
    output logic                       feed_valid,
    output logic [ROW_AW-1:0]          row_addr,
    output logic [NEUR_AW-1:0]         neuron_idx,
    output logic                       done,
    output logic [NEUR_AW-1:0]         class_out,
    output logic signed [RESULT_W-1:0] max_value,
    output logic                       error
);
    import dp_pkg::*;

    state_t                     state_q, state_d;
    logic [ROW_AW-1:0]          row_q, row_d;
    logic [NEUR_AW-1:0]         neuron_q, neuron_d;
    logic signed [RESULT_W-1:0] result_q, result_d;

`ifdef DP_SCHED_TIMEOUT_EN
    localparam int unsigned WaitW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [WaitW-1:0] wait_q, wait_d;
    logic             error_q, error_d;
`endif

    always_comb begin
        state_d  = state_q;
        row_d    = row_q;
        neuron_d = neuron_q;
        result_d = result_q;
`ifdef DP_SCHED_TIMEOUT_EN
        wait_d   = wait_q;
        error_d  = error_q;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d  = CLEAR;
                    neuron_d = '0;
`ifdef DP_SCHED_TIMEOUT_EN
                    error_d  = 1'b0;
`endif
                end
            end
            CLEAR: begin
                row_d   = '0;
                state_d = FEED;
            end
            FEED: begin
                if (feed_ready) begin
                    if (row_q == ROW_AW'(ROWS - 1)) begin
                        row_d   = '0;
                        state_d = WAIT;
`ifdef DP_SCHED_TIMEOUT_EN
                        wait_d  = '0;
`endif
                    end else begin
                        row_d = row_q + ROW_AW'(1);
                    end
                end
            end
            WAIT: begin
                if (result_valid) begin
                    result_d = result_in;
                    state_d  = CAPTURE;
                end
`ifdef DP_SCHED_TIMEOUT_EN
                // Give up on a silent engine; best-so-far class/value stay as reported.
                else if (wait_q == WaitW'(TIMEOUT_CYCLES - 1)) begin
                    error_d = 1'b1;
                    state_d = FINISH;
                end else begin
                    wait_d = wait_q + WaitW'(1);
                end
`endif
            end
            CAPTURE: begin
                if (neuron_q == NEUR_AW'(NUM_NEURONS - 1)) begin
                    state_d = FINISH;
                end else begin
                    neuron_d = neuron_q + NEUR_AW'(1);
                    state_d  = CLEAR;
                end
            end
            FINISH: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (GlobalReset) begin
            state_q  <= IDLE;
            row_q    <= '0;
            neuron_q <= '0;
            result_q <= '0;
`ifdef DP_SCHED_TIMEOUT_EN
            wait_q   <= '0;
            error_q  <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            row_q    <= row_d;
            neuron_q <= neuron_d;
            result_q <= result_d;
`ifdef DP_SCHED_TIMEOUT_EN
            wait_q   <= wait_d;
            error_q  <= error_d;
`endif
        end
    end

    dp_argmax_tracker #(
        .RESULT_W (RESULT_W),
        .NEUR_AW  (NEUR_AW)
    ) u_argmax (
        .clk         (clk),
        .GlobalReset (GlobalReset),
        .capture     (state_q == CAPTURE),
        .first       (neuron_q == '0),
        .index       (neuron_q),
        .value       (result_q),
        .class_out   (class_out),
        .max_value   (max_value)
    );

    assign busy         = (state_q != IDLE) && (state_q != FINISH);
    assign engine_clear = (state_q == CLEAR);
    assign feed_valid   = (state_q == FEED);
    assign done         = (state_q == FINISH);
    assign row_addr     = row_q;
    assign neuron_idx   = neuron_q;
`ifdef DP_SCHED_TIMEOUT_EN
    assign error        = error_q;
`else
    assign error        = 1'b0;
`endif

endmodule

// File: doc/dot_product_scheduler.md
Name: dot_product_scheduler

Overview:
Sequences the 28-lane fixed-point dot-product engine across all output neurons of one MNIST layer (784 inputs = 28 rows x 28 pixels per neuron).
- Per neuron: clears the engine, streams ROWS row addresses to the pixel/weight memories, waits for the engine result, and updates a running signed argmax.
- Sits between the top-level classifier control and the dot-product datapath plus its weight/pixel memories.

Parameters:
ROWS, 28, row beats per neuron (784/28)
NUM_NEURONS, 10, output neurons per image
RESULT_W, 26, engine result width (signed two's complement)
ROW_AW, 5, row address width, clog2(ROWS)
NEUR_AW, 4, neuron index width, clog2(NUM_NEURONS)
TIMEOUT_CYCLES, 512, WAIT-state watchdog limit (used only with the macro)

Ports:
clk  in  1  clock, rising edge
GlobalReset  in  1  synchronous reset, active-high
start  in  1  one-cycle request to classify one image
feed_ready  in  1  memories can present row row_addr this cycle
result_valid  in  1  engine result_in valid (single-cycle pulse)
result_in  in  RESULT_W  engine dot product incl. bias, signed
busy  out  1  high from accepted start until done
engine_clear  out  1  one-cycle engine accumulator clear
feed_valid  out  1  row_addr/neuron_idx valid for the engine this cycle
row_addr  out  ROW_AW  current row 0..ROWS-1
neuron_idx  out  NEUR_AW  current neuron 0..NUM_NEURONS-1
done  out  1  one-cycle completion pulse
class_out  out  NEUR_AW  argmax neuron index; held after done
max_value  out  RESULT_W  result of the winning neuron; held after done
error  out  1  watchdog fired for last run; tied 0 without the macro

Behaviour:
- Reset, synchronous, GlobalReset=1 at clk edge: state IDLE; all outputs 0; counters 0; valid from the next cycle. Reset mid-run aborts the run with no done pulse.
- States: IDLE, CLEAR, FEED, WAIT, CAPTURE, FINISH.
- IDLE: start=1 -> CLEAR. On acceptance: neuron_idx=0, error=0, busy=1. class_out and max_value keep their old values until the first CAPTURE.
- start while busy is ignored; it is not queued.
- CLEAR: engine_clear=1 for exactly 1 cycle; row_addr=0 -> FEED.
- FEED:
  - feed_valid=1 every cycle.
  - A beat transfers when feed_valid && feed_ready. Only then does row_addr increment.
  - feed_ready=0 holds row_addr and stays in FEED.
  - Beat at row_addr=ROWS-1 -> WAIT; row_addr wraps to 0.
  - Exactly ROWS beats per neuron.
- WAIT: feed_valid=0. result_valid=1 -> CAPTURE, latching result_in. result_valid in any other state is ignored.
- CAPTURE, 1 cycle, signed compare:
  - Neuron 0 is always taken: max_value=result, class_out=0.
  - Otherwise take the new result only if result > max_value (strict). On ties the lower index wins.
  - If neuron_idx==NUM_NEURONS-1 -> FINISH; else neuron_idx+1 -> CLEAR.
- FINISH: done=1 for 1 cycle, busy=0 -> IDLE. A start in the cycle after done is accepted.
- Per-neuron latency with feed_ready=1 and engine latency L: 1 (CLEAR) + ROWS + L + 1 (CAPTURE) cycles.

Optional Feature:
DP_SCHED_TIMEOUT_EN
- Defined:
  - A WAIT-cycle counter resets on entry to WAIT.
  - When the counter reaches TIMEOUT_CYCLES with no result_valid: error=1, jump to FINISH. done pulses; class_out/max_value hold their best-so-far values.
  - error stays sticky until the next accepted start or reset.
- Undefined: no counter; WAIT waits indefinitely; error is constant 0.

Decomposition:
- Shared package dp_pkg holds:
  - the state enum (IDLE..FINISH);
  - constants ROWS=28, PIXELS=784, NUM_NEURONS=10, RESULT_W=26, WEIGHT_W=19, PIXEL_W=10.
- One sub-module: dp_argmax_tracker. It holds the signed compare/update registers, with first/capture/index/value inputs and class_out/max_value outputs.
- The FSM and counters stay in the top module.

Test Plan:
- Reset then start, feed_ready=1, engine returns results 5,-3,12,12,0,7,-20,1,2,11 with L=6 -> 10x28 feed beats, row_addr 0..27 each neuron; done after 10*(1+28+6+1)+1 cycles; class_out=2, max_value=12 (tie keeps 2).
- All results negative (-100..-91, neuron 9 = -91) -> class_out=9, max_value=-91; verifies signed compare.
- feed_ready toggled 1/0 each cycle -> exactly 28 beats per neuron; row_addr holds during stalls; no engine_clear during FEED.
- start pulsed while busy, and result_valid pulsed during FEED -> both ignored; final outputs identical to the no-pulse run.
- GlobalReset=1 mid-FEED of neuron 4 -> next cycle all outputs 0, state IDLE, no done pulse; a new start completes a normal run.
- DP_SCHED_TIMEOUT_EN, TIMEOUT_CYCLES=16, engine never responds for neuron 3 -> done 16 cycles after WAIT entry, error=1, class_out/max_value equal the best of neurons 0-2; next start clears error.
